// File: rtl/pisa_alu_pkg.sv
// Shared ALU definitions: legal opcode encodings, legality check and pipeline latency.
package pisa_alu_pkg;

    localparam int ALU_LATENCY = 1;

    // 0x3 (div), 0xC (mod) and every unlisted code are reserved.
    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_AND = 4'h4,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_SLL = 4'h8,
        OP_SRL = 4'h9,
        OP_SRA = 4'hA
    } alu_op_e;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
            OP_XOR, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO with registered occupancy count and pointer wrap modulo DEPTH.
module alu_result_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: every register in a clocked block is assigned with <= so all of
    // them sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage is reset only because it is tiny and the head must read
    // zero out of reset; larger buffers should leave storage unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/result-collection stage around a one-cycle registered ALU, with credit-based
// admission so the ALU pipeline itself never needs to stall.
module alu_issue #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       alu_opcode,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    import pisa_alu_pkg::*;

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 32 + TAG_W + 1;

    logic             s1_valid;
    logic             s1_illegal;
    logic [3:0]       s1_opcode;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             s2_illegal;
    logic [TAG_W-1:0] s2_tag;
    logic             accept;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] fifo_head;

    // Credits count everything that will eventually occupy a FIFO slot; built from
    // registered state only so out_ready never reaches in_ready combinationally.
    assign credit_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(s1_valid)
                       + (CNT_W + 1)'(s2_valid);
    assign in_ready    = credit_used < (CNT_W + 1)'(DEPTH);
    assign accept      = in_valid && in_ready;

    // Operand registers hold their last value while s1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_opcode  <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_tag     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_opcode  <= in_opcode;
                s1_a       <= in_a;
                s1_b       <= in_b;
                s1_tag     <= in_tag;
                s1_illegal <= !alu_op_legal(in_opcode);
            end
        end
    end

    // s2 shadows the ALU's unreset result register; only s2_valid qualifies alu_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else begin
            s2_valid   <= s1_valid;
            s2_illegal <= s1_illegal;
            s2_tag     <= s1_tag;
        end
    end

    assign alu_opcode = s1_opcode;
    assign alu_a      = s1_a;
    assign alu_b      = s1_b;
    assign push_data  = {(s2_illegal ? 32'd0 : alu_result), s2_tag, s2_illegal};

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_valid),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid = fifo_count != '0;
    assign {out_result, out_tag, out_illegal} = fifo_head;
    assign busy = s1_valid || s2_valid || out_valid;

endmodule
